// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter and its RAM wrapper.
package ram_arb_pkg;

  localparam logic PORT_1 = 1'b0;
  localparam logic PORT_2 = 1'b1;

  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 1024;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_entry_t;

  localparam rd_entry_t RD_ENTRY_IDLE = '{valid: 1'b0, port: PORT_1};

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshake and RAM-wrapper control bundle for ram_arbiter.
interface ram_arbiter_if;

  logic req_1;
  logic req_2;
  logic we_1;
  logic we_2;
  logic lock_1;
  logic lock_2;
  logic gnt_1;
  logic gnt_2;
  logic rvalid_1;
  logic rvalid_2;
  logic ram_ena;
  logic ram_read_write;
  logic ram_addr_sel;
  logic ram_out_sel;
  logic busy;

  modport master (
    output req_1, req_2, we_1, we_2, lock_1, lock_2,
    input  gnt_1, gnt_2, rvalid_1, rvalid_2,
    input  ram_ena, ram_read_write, ram_addr_sel, ram_out_sel, busy
  );

  modport slave (
    input  req_1, req_2, we_1, we_2, lock_1, lock_2,
    output gnt_1, gnt_2, rvalid_1, rvalid_2,
    output ram_ena, ram_read_write, ram_addr_sel, ram_out_sel, busy
  );

endinterface

// File: rtl/ram_arbiter_rd_return_pipe.sv
// RD_LAT-deep read-return tracker: tags each granted read with its port and
// presents the tag at the tail when the RAM data is due.
module rd_return_pipe
  import ram_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  rd_entry_t i_push,
  output rd_entry_t o_tail,
  output logic      o_out_sel,
  output logic      o_busy
);

  rd_entry_t r_pipe [RD_LAT];
  rd_entry_t w_next_tail;
  logic      r_out_sel;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_pipe[i] <= RD_ENTRY_IDLE;
      end
    end else begin
      r_pipe[0] <= i_push;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Entry about to reach the tail; out_sel is loaded from it so the mux
  // setting is registered yet already correct in the rvalid cycle.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign w_next_tail = i_push;
    end else begin : g_latn
      assign w_next_tail = r_pipe[RD_LAT-2];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_out_sel <= PORT_1;
    end else if (w_next_tail.valid) begin
      r_out_sel <= w_next_tail.port;
    end
  end

  always_comb begin
    o_busy = 1'b0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      o_busy = o_busy | r_pipe[i].valid;
    end
  end

  assign o_tail    = r_pipe[RD_LAT-1];
  assign o_out_sel = r_out_sel;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter with optional per-port lock, sequencing
// accesses to the shared single-port RAM wrapper.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  ram_arbiter_if.slave  bus
);

  logic      r_last;
  logic      r_locked;
  logic      r_lock_owner;

  logic [1:0] w_req;
  logic [1:0] w_we;
  logic [1:0] w_lock;
  logic [1:0] w_gnt;
  logic       w_any;
  logic       w_gnt_port;
  rd_entry_t  w_push;
  rd_entry_t  w_tail;
  logic       w_out_sel;
  logic       w_busy;

  assign w_req  = {bus.req_2,  bus.req_1};
  assign w_we   = {bus.we_2,   bus.we_1};
  assign w_lock = {bus.lock_2, bus.lock_1};

  always_comb begin
    w_gnt = '0;
    if (!i_reset) begin
      w_gnt = '0;
    end else if (r_locked && w_req[r_lock_owner]) begin
      w_gnt[r_lock_owner] = 1'b1;
    end else if (w_req == 2'b11) begin
      w_gnt[~r_last] = 1'b1;
    end else begin
      w_gnt = w_req;
    end
  end

  assign w_any      = |w_gnt;
  assign w_gnt_port = w_gnt[1];

  // Lock drops on an idle edge only when the owner stopped requesting; any
  // grant re-samples the lock of whichever port won.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_last       <= PORT_2;
      r_locked     <= 1'b0;
      r_lock_owner <= PORT_1;
    end else if (w_any) begin
      r_last       <= w_gnt_port;
      r_locked     <= w_lock[w_gnt_port];
      r_lock_owner <= w_gnt_port;
    end else if (r_locked && !w_req[r_lock_owner]) begin
      r_locked     <= 1'b0;
    end
  end

  always_comb begin
    w_push = RD_ENTRY_IDLE;
    if (w_any && !w_we[w_gnt_port]) begin
      w_push.valid = 1'b1;
      w_push.port  = w_gnt_port;
    end
  end

  rd_return_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_return_pipe (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_push    (w_push),
    .o_tail    (w_tail),
    .o_out_sel (w_out_sel),
    .o_busy    (w_busy)
  );

  assign bus.gnt_1          = w_gnt[0];
  assign bus.gnt_2          = w_gnt[1];
  assign bus.ram_ena        = w_any;
  assign bus.ram_read_write = w_any & w_we[w_gnt_port];
  assign bus.ram_addr_sel   = w_gnt[1];
  assign bus.ram_out_sel    = w_out_sel;
  assign bus.busy           = w_busy;
  assign bus.rvalid_1       = i_reset & w_tail.valid & (w_tail.port == PORT_1);
  assign bus.rvalid_2       = i_reset & w_tail.valid & (w_tail.port == PORT_2);

endmodule
